// File: rtl/constraint_sampler_if.sv
// Candidate/result bus to the constraint checker plus the sample output handshake.
// sample_valid/sample_ready: a sample transfers on any rising edge where both are high; once raised,
// sample_valid and sample_data hold steady until that transfer (only rst may drop them early).
interface constraint_sampler_if #(
   parameter int WIDTH = 64
) ();
   logic [WIDTH-1:0] cand;
   logic             sat;
   logic             sample_valid;
   logic             sample_ready;
   logic [WIDTH-1:0] sample_data;

   modport master (
      output cand,
      output sample_valid,
      output sample_data,
      input  sat,
      input  sample_ready
   );

   modport slave (
      input  cand,
      input  sample_valid,
      input  sample_data,
      output sat,
      output sample_ready
   );
endinterface

// File: rtl/constraint_sampler.sv
// LFSR-driven rejection sampler feeding a combinational constraint checker.
// Define CONSTRAINT_SAMPLER_STATS_EN to build the saturating accept/reject counters.
module constraint_sampler #(
   parameter int          WIDTH     = 64,
   parameter int          MAX_TRIES = 1024,
   parameter logic [63:0] SEED      = 64'h0000_0000_0000_0001
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  seed_load,
   input  logic [63:0]           seed_in,
   constraint_sampler_if.master  bus,
   output logic [15:0]           tries,
   output logic                  busy,
   output logic                  fail,
   output logic [31:0]           acc_cnt,
   output logic [31:0]           rej_cnt,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GEN   = 3'd1,
      S_CHECK = 3'd2,
      S_HOLD  = 3'd3,
      S_FAIL  = 3'd4
   } state_t;

   // Galois taps for x^64+x^63+x^61+x^60+1 in right-shift form.
   localparam logic [63:0] TAPS  = 64'hD800_0000_0000_0000;
   localparam logic [15:0] MAX_T = 16'(MAX_TRIES);

   state_t           state, state_next;
   logic [63:0]      lfsr;
   logic [63:0]      lfsr_step;
   logic [WIDTH-1:0] cand_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             load_seed, begin_req, accept, reject, handshake;

   assign lfsr_step = {1'b0, lfsr[63:1]} ^ (lfsr[0] ? TAPS : 64'h0);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      load_seed  = 1'b0;
      begin_req  = 1'b0;
      accept     = 1'b0;
      reject     = 1'b0;
      handshake  = 1'b0;
      case (state)
         S_IDLE: begin
            if (seed_load) begin
               load_seed = 1'b1;
            end else if (start) begin
               begin_req  = 1'b1;
               state_next = S_GEN;
            end
         end
         S_GEN:   state_next = S_CHECK;
         S_CHECK: begin
            if (bus.sat) begin
               accept     = 1'b1;
               state_next = S_HOLD;
            end else begin
               reject     = 1'b1;
               state_next = (tries + 16'd1 == MAX_T) ? S_FAIL : S_GEN;
            end
         end
         S_HOLD: begin
            if (valid_q && bus.sample_ready) begin
               handshake  = 1'b1;
               state_next = S_IDLE;
            end
         end
         S_FAIL:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // fail is registered off the FAIL state, so the pulse lands the cycle after FAIL.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr    <= SEED;
         cand_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         tries   <= '0;
         fail    <= 1'b0;
      end else begin
         fail <= (state == S_FAIL);
         if (load_seed) lfsr <= (seed_in == 64'h0) ? SEED : seed_in;
         if (begin_req) tries <= '0;
         if (state == S_GEN) begin
            lfsr   <= lfsr_step;
            cand_q <= lfsr_step[WIDTH-1:0];
         end
         if (accept) begin
            data_q  <= cand_q;
            valid_q <= 1'b1;
         end
         if (reject)    tries   <= tries + 16'd1;
         if (handshake) valid_q <= 1'b0;
      end
   end

`ifdef CONSTRAINT_SAMPLER_STATS_EN
   logic [31:0] acc_q, rej_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         rej_q <= '0;
      end else begin
         if (accept && acc_q != 32'hFFFF_FFFF) acc_q <= acc_q + 32'd1;
         if (reject && rej_q != 32'hFFFF_FFFF) rej_q <= rej_q + 32'd1;
      end
   end

   assign acc_cnt = acc_q;
   assign rej_cnt = rej_q;
`else
   assign acc_cnt = '0;
   assign rej_cnt = '0;
`endif

   assign bus.cand         = cand_q;
   assign bus.sample_valid = valid_q;
   assign bus.sample_data  = data_q;
   assign busy             = (state != S_IDLE);
   assign dbg_state        = state;

endmodule
